// File: rtl/scalar_operand_collector.sv
// Scalar operand collector: accepts an rs1/rs2 read request, drives the
// register file read ports, waits out its one-cycle registered read, applies
// write-back forwarding and presents both operands with a valid/ready handshake.
module scalar_operand_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_rs1_addr,
  input  logic [4:0]            req_rs2_addr,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [4:0]            rf_rs1_addr,
  output logic [4:0]            rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs1,
  output logic [DATA_WIDTH-1:0] out_rs2,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  // IDLE: waiting for a request; WAIT: register file samples addresses;
  // CAPT: read data available, operands captured; HOLD: presenting operands.
  typedef enum logic [1:0] {IDLE, WAIT, CAPT, HOLD} state_t;

  state_t                  state, state_next;
  logic                    accept;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic                    fwd1, fwd2;
  logic [DATA_WIDTH-1:0]   fwd_data1, fwd_data2;
  logic [DATA_WIDTH-1:0]   op1_next, op2_next;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Operand select at capture: x0 is hardwired zero, then youngest write wins
  // (commit at this edge, then commit snooped one edge earlier, then file data).
  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [4:0]            rs,
    input logic                  fwd,
    input logic [DATA_WIDTH-1:0] fwd_data,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  wb_hit_valid,
    input logic [4:0]            wb_hit_addr,
    input logic [DATA_WIDTH-1:0] wb_hit_data
  );
    if (rs == 5'd0)                                return '0;
    else if (wb_hit_valid && wb_hit_addr == rs)    return wb_hit_data;
    else if (fwd)                                  return fwd_data;
    else                                           return rf_data;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: if (accept)    state_next = WAIT;
      WAIT:                state_next = CAPT;
      CAPT:                state_next = HOLD;
      HOLD: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Capture-time operand values with forwarding applied.
  always_comb begin
    op1_next = select_operand(rf_rs1_addr, fwd1, fwd_data1, rf_rs1_data,
                              wb_valid, wb_addr, wb_data);
    op2_next = select_operand(rf_rs2_addr, fwd2, fwd_data2, rf_rs2_data,
                              wb_valid, wb_addr, wb_data);
  end

  // Control and output registers: request latch, forward flags, handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_rs1_addr <= '0;
      rf_rs2_addr <= '0;
      tag_q       <= '0;
      fwd1        <= 1'b0;
      fwd2        <= 1'b0;
      out_valid   <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_tag     <= '0;
    end else begin
      if (accept) begin
        rf_rs1_addr <= req_rs1_addr;
        rf_rs2_addr <= req_rs2_addr;
        tag_q       <= req_tag;
        fwd1        <= 1'b0;
        fwd2        <= 1'b0;
      end
      if (state == WAIT) begin
        // The file samples its addresses at this edge and misses this commit.
        if (wb_valid && wb_addr == rf_rs1_addr && rf_rs1_addr != 5'd0) fwd1 <= 1'b1;
        if (wb_valid && wb_addr == rf_rs2_addr && rf_rs2_addr != 5'd0) fwd2 <= 1'b1;
      end
      if (state == CAPT) begin
        out_rs1   <= op1_next;
        out_rs2   <= op2_next;
        out_tag   <= tag_q;
        out_valid <= 1'b1;
      end
      if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

  // Forward data payload, only meaningful while its flag is set.
  always_ff @(posedge clk) begin
    // NOTE: no reset here on purpose; the payload is qualified by fwd1/fwd2,
    // which are reset, so clearing it would only add reset fan-out.
    if (state == WAIT && wb_valid) begin
      if (wb_addr == rf_rs1_addr) fwd_data1 <= wb_data;
      if (wb_addr == rf_rs2_addr) fwd_data2 <= wb_data;
    end
  end

endmodule

// File: doc/scalar_operand_collector.md
Name: scalar_operand_collector

Overview:
- Issue-side counterpart of the scalar register file. Accepts an operand-read request (rs1/rs2 indices plus tag) and drives the register file's read-address ports.
- Waits out the file's one-cycle registered read latency and applies write-back forwarding for same-cycle and in-flight commits.
- Presents both operands to the ALU/LSU stage with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, operand/register width.
- TAG_WIDTH, 4, width of opaque request tag (warp/instruction id) carried to output.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  operand request valid
- req_ready  output  1  collector can accept request
- req_rs1_addr  input  5  source register 1 index
- req_rs2_addr  input  5  source register 2 index
- req_tag  input  TAG_WIDTH  request tag
- rf_rs1_addr  output  5  read address to register file port 1
- rf_rs2_addr  output  5  read address to register file port 2
- rf_rs1_data  input  DATA_WIDTH  register file read data 1 (registered, 1-cycle latency)
- rf_rs2_data  input  DATA_WIDTH  register file read data 2
- wb_valid  input  1  register file write committing at this edge
- wb_addr  input  5  write destination index
- wb_data  input  DATA_WIDTH  write data
- out_valid  output  1  operands valid
- out_ready  input  1  consumer accepts operands
- out_rs1  output  DATA_WIDTH  operand 1
- out_rs2  output  DATA_WIDTH  operand 2
- out_tag  output  TAG_WIDTH  tag of the request

Behaviour:
- Reset clock and level: clock is clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE, out_valid=0.
  - out_rs1, out_rs2, out_tag, rf_rs1_addr, rf_rs2_addr all 0.
  - forward flags cleared.
- Reset mid-operation aborts the request; no output is produced.
- req_ready = (state==IDLE), combinational from state only.
- FSM states IDLE, WAIT, CAPT, HOLD. Edge E0 is the accept edge (req_valid & req_ready):
  - IDLE, on accept at E0: latch rs1/rs2/tag; rf_rs*_addr registered to the request indices; go to WAIT.
  - WAIT, at E1: the register file samples addresses; snoop write-back; go to CAPT.
  - CAPT, at E2: load out_rs1/out_rs2 with forwarding applied; out_valid=1; go to HOLD.
  - HOLD: outputs stable while out_valid & !out_ready. On out_ready at edge: out_valid=0, go to IDLE.
- Timing:
  - Latency: out_valid high in the cycle after E2 (2 edges after accept).
  - Minimum request-to-request spacing is 4 cycles when out_ready is held high.
  - rf_rs*_addr are held constant from E0 until the next accept.
- Forwarding (per operand, independent):
  - The register file read at E1 misses commits at E1 and E2 (non-blocking update).
  - E1 snoop: if wb_valid and wb_addr==rsN and rsN!=0, set fwdN=1 and fwd_dataN=wb_data.
  - E2 selection, priority youngest first:
    1. E2 wb hit uses wb_data.
    2. Otherwise fwdN uses fwd_dataN.
    3. Otherwise rf_rsN_data.
  - rs1==rs2 with a hit forwards to both operands.
- Zero register: rsN==0 always yields operand 0, regardless of rf data or wb traffic.
- HOLD stability: writes during HOLD are not merged; the operand snapshot is taken at E2. Hazards after capture are the scoreboard's responsibility.
- req_valid outside IDLE is ignored. The requester must hold its request until req_ready.
- fwd flags clear on every accept.

Test Plan:
- Reset, then request rs1=3, rs2=5 with rf data 0x11/0x22, out_ready=1 -> rf_rs1_addr=3 and rf_rs2_addr=5 after E0; out_valid at E2; out_rs1=0x11, out_rs2=0x22; tag echoed; req_ready returns high one cycle later.
- wb_valid at E1 to reg 3 with 0xAAAA0000, rf returns stale 0x11 -> out_rs1=0xAAAA0000, out_rs2 unaffected.
- wb to reg 3 at E1 (0x1) and E2 (0x2) -> out_rs1=0x2 (youngest wins).
- rs1=0, rs2=0 with rf returning 0xFFFFFFFF and wb to reg 0 with 0x5 -> both operands 0.
- out_ready low for 5 cycles while wb hits reg 5 with 0x99 -> out_rs2 stays 0x22; req_ready low; a new req_valid is ignored; after out_ready, IDLE.
- reset asserted in CAPT -> next cycle out_valid=0, req_ready=1, outputs 0; a fresh request completes normally.
